// File: rtl/frame_buf_ctrl_if.sv
// Stream, display and data_mem signals of the ping-pong frame buffer controller.
// master is the controller's view; slave is the capture/display/memory side.
interface frame_buf_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  wr_frame_done;
    logic                  rd_frame_done;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport master (
        input  in_valid, in_data, out_ready, mem_rd_data,
        output in_ready, out_valid, out_data, wr_frame_done, rd_frame_done,
               mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr
    );

    modport slave (
        output in_valid, in_data, out_ready, mem_rd_data,
        input  in_ready, out_valid, out_data, wr_frame_done, rd_frame_done,
               mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr
    );
endinterface

// File: rtl/frame_buf_ctrl.sv
// Ping-pong frame buffer controller: the writer fills one data_mem bank while
// the reader drains the other, each side swapping banks on its own frame end.
module frame_buf_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    frame_buf_ctrl_if.master bus
);
    localparam int FRAME_LEN = 2 ** (ADDR_WIDTH - 1);
    localparam int PW        = ADDR_WIDTH - 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        R_IDLE,
        R_ISSUE,
        R_CAPTURE,
        R_PRESENT
    } rd_state_t;

    rd_state_t             r_state;
    rd_state_t             w_state_nxt;
    logic                  r_wr_bank;
    logic [PW-1:0]         r_wr_ptr;
    logic                  r_rd_bank;
    logic [PW-1:0]         r_rd_ptr;
    logic [1:0]            r_bank_full;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_wr_done;
    logic                  r_rd_done;

    logic                  w_in_ready;
    logic                  w_wr_acc;
    logic                  w_wr_last;
    logic                  w_rd_hs;
    logic                  w_rd_last;
    logic                  w_mem_rd_en;
    logic [1:0]            w_full_set;
    logic [1:0]            w_full_clr;

    assign w_in_ready = reset & ~r_bank_full[r_wr_bank];
    assign w_wr_acc   = bus.in_valid & w_in_ready;
    assign w_wr_last  = w_wr_acc & (r_wr_ptr == LAST_PTR);
    assign w_rd_hs    = (r_state == R_PRESENT) & bus.out_ready;
    assign w_rd_last  = w_rd_hs & (r_rd_ptr == LAST_PTR);

    // The writer only sets a non-full bank and the reader only clears a full
    // one, so set and clear never collide on the same bit.
    assign w_full_set = w_wr_last ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_full_clr = w_rd_last ? (2'b01 << r_rd_bank) : 2'b00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_bank <= 1'b0;
            r_wr_ptr  <= '0;
            r_wr_done <= 1'b0;
        end else begin
            r_wr_done <= w_wr_last;
            if (w_wr_acc) begin
                if (w_wr_last) begin
                    r_wr_ptr  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_ptr  <= r_wr_ptr + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bank_full <= 2'b00;
        end else begin
            r_bank_full <= (r_bank_full | w_full_set) & ~w_full_clr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mem_rd_en = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (r_bank_full[r_rd_bank]) begin
                    w_state_nxt = R_ISSUE;
                end
            end
            R_ISSUE: begin
                w_mem_rd_en = 1'b1;
                w_state_nxt = R_CAPTURE;
            end
            R_CAPTURE: begin
                w_state_nxt = R_PRESENT;
            end
            R_PRESENT: begin
                if (bus.out_ready) begin
                    w_state_nxt = (r_rd_ptr == LAST_PTR) ? R_IDLE : R_ISSUE;
                end
            end
            default: begin
                w_state_nxt = R_IDLE;
            end
        endcase
    end

    // mem_rd_data is valid during R_CAPTURE, one cycle after the R_ISSUE read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_bank   <= 1'b0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_rd_done   <= 1'b0;
        end else begin
            r_rd_done <= w_rd_last;
            if (r_state == R_CAPTURE) begin
                r_out_data  <= bus.mem_rd_data;
                r_out_valid <= 1'b1;
            end
            if (w_rd_hs) begin
                r_out_valid <= 1'b0;
                if (w_rd_last) begin
                    r_rd_ptr  <= '0;
                    r_rd_bank <= ~r_rd_bank;
                end else begin
                    r_rd_ptr  <= r_rd_ptr + PW'(1);
                end
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.mem_wr_en     = w_wr_acc;
    assign bus.mem_wr_addr   = {r_wr_bank, r_wr_ptr};
    assign bus.mem_wr_data   = bus.in_data;
    assign bus.mem_rd_en     = w_mem_rd_en;
    assign bus.mem_rd_addr   = {r_rd_bank, r_rd_ptr};
    assign bus.out_valid     = r_out_valid;
    assign bus.out_data      = r_out_data;
    assign bus.wr_frame_done = r_wr_done;
    assign bus.rd_frame_done = r_rd_done;
endmodule
